// File: rtl/updown_mod_counter.sv
// Loadable up/down modulo counter with run-time limit, wrap/saturate modes,
// cascade carry and a registered wrap pulse plus sticky saturation flag.
module updown_mod_counter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             en,
  input  logic             cin,
  input  logic             up,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             cout,
  output logic             wrap,
  output logic             sat_flag
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic             step;
  logic [WIDTH-1:0] count_nx;
  logic             wrap_nx;
  logic             sat_nx;

  assign step = en & cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= RESET_VAL;
      wrap     <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      count    <= count_nx;
      wrap     <= wrap_nx;
      sat_flag <= sat_nx;
    end
  end

  // Priority: clr > load > step > hold. The +1/-1 are only taken inside
  // ranges where they cannot overflow, even if limit was lowered below count.
  always_comb begin
    count_nx = count;
    wrap_nx  = 1'b0;
    sat_nx   = sat_flag;
    if (clr) begin
      count_nx = ZERO;
      sat_nx   = 1'b0;
    end else if (load) begin
      count_nx = (load_val > limit) ? limit : load_val;
    end else if (step) begin
      if (up) begin
        if (count < limit) begin
          count_nx = count + ONE;
        end else if (!sat_mode) begin
          count_nx = ZERO;
          wrap_nx  = 1'b1;
        end else begin
          count_nx = limit;
          sat_nx   = 1'b1;
        end
      end else begin
        if (count > limit) begin
          count_nx = limit;
        end else if (count != ZERO) begin
          count_nx = count - ONE;
        end else if (!sat_mode) begin
          count_nx = limit;
          wrap_nx  = 1'b1;
        end else begin
          count_nx = ZERO;
          sat_nx   = 1'b1;
        end
      end
    end
  end

  assign tc   = up ? (count >= limit) : (count == ZERO);
  assign cout = tc & en & cin & ~sat_mode;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: single stage with RESET_VAL=5 plus a
// two-stage decade cascade, checked through an expected-value queue.
module tb_updown_mod_counter;

  localparam int SB_W = 18;

  logic clk = 1'b0;
  logic rst;
  logic clr, load, en, cin, up, sat_mode;
  logic [7:0] load_val, limit;
  logic [7:0] count;
  logic tc, cout, wrap, sat_flag;

  logic c_clr, c_en;
  logic [7:0] lo_count, hi_count;
  logic lo_tc, lo_cout, lo_wrap, lo_sat;
  logic hi_tc, hi_cout, hi_wrap, hi_sat;

  logic [SB_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(8), .RESET_VAL(8'd5)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .limit(limit), .en(en), .cin(cin), .up(up), .sat_mode(sat_mode),
    .count(count), .tc(tc), .cout(cout), .wrap(wrap), .sat_flag(sat_flag)
  );

  updown_mod_counter #(.WIDTH(8), .RESET_VAL(8'd0)) u_lo (
    .clk(clk), .rst(rst), .clr(c_clr), .load(1'b0), .load_val(8'd0),
    .limit(8'd9), .en(c_en), .cin(1'b1), .up(1'b1), .sat_mode(1'b0),
    .count(lo_count), .tc(lo_tc), .cout(lo_cout), .wrap(lo_wrap), .sat_flag(lo_sat)
  );

  updown_mod_counter #(.WIDTH(8), .RESET_VAL(8'd0)) u_hi (
    .clk(clk), .rst(rst), .clr(c_clr), .load(1'b0), .load_val(8'd0),
    .limit(8'd9), .en(c_en), .cin(lo_cout), .up(1'b1), .sat_mode(1'b0),
    .count(hi_count), .tc(hi_tc), .cout(hi_cout), .wrap(hi_wrap), .sat_flag(hi_sat)
  );

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [SB_W-1:0] got, e;
    exp_q.push_back({8'h00, 8'd5, 1'b0, 1'b0});
    got = {8'h00, count, wrap, sat_flag};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL reset_state got=%h exp=%h", got, e); end
    rst = 1'b0;
    limit = 8'd20; up = 1'b1; en = 1'b1; cin = 1'b1; sat_mode = 1'b0;
    for (int i = 6; i <= 9; i++) begin
      exp_q.push_back({8'h00, 8'(i), 1'b0, 1'b0});
      step_cycle();
      got = {8'h00, count, wrap, sat_flag};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL pre_reset_count got=%h exp=%h", got, e); end
    end
    rst = 1'b1;
    en = 1'b0;
    #1;
    exp_q.push_back({8'h00, 8'd5, 1'b0, 1'b0});
    got = {8'h00, count, wrap, sat_flag};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL async_reset got=%h exp=%h", got, e); end
    rst = 1'b0;
    clr = 1'b1; load = 1'b1; load_val = 8'd7; en = 1'b1;
    exp_q.push_back({8'h00, 8'd0, 1'b0, 1'b0});
    step_cycle();
    got = {8'h00, count, wrap, sat_flag};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL clr_over_load got=%h exp=%h", got, e); end
    clr = 1'b0; load = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [SB_W-1:0] got, e;
    logic [7:0] cur;
    limit = 8'd9; up = 1'b1; sat_mode = 1'b0; en = 1'b1; cin = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cur = 8'(i % 10);
      #1;
      checks++;
      if ({tc, cout} !== {(cur == 8'd9), (cur == 8'd9)}) begin
        errors++;
        $display("FAIL up_tc_cout count=%0d got=%b%b exp=%b%b", cur, tc, cout, cur == 8'd9, cur == 8'd9);
      end
      exp_q.push_back({8'h00, 8'((i + 1) % 10), (cur == 8'd9), 1'b0});
      step_cycle();
      got = {8'h00, count, wrap, sat_flag};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL up_wrap_seq step=%0d got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_down_sat();
    logic [SB_W-1:0] got, e;
    logic [7:0] exp_cnt [4];
    logic       exp_sat [4];
    exp_cnt[0] = 8'd1; exp_cnt[1] = 8'd0; exp_cnt[2] = 8'd0; exp_cnt[3] = 8'd0;
    exp_sat[0] = 1'b0; exp_sat[1] = 1'b0; exp_sat[2] = 1'b1; exp_sat[3] = 1'b1;
    limit = 8'd9; up = 1'b0; sat_mode = 1'b1; load_val = 8'd2; load = 1'b1;
    exp_q.push_back({8'h00, 8'd2, 1'b0, 1'b0});
    step_cycle();
    got = {8'h00, count, wrap, sat_flag};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL down_load got=%h exp=%h", got, e); end
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({8'h00, exp_cnt[i], 1'b0, exp_sat[i]});
      step_cycle();
      got = {8'h00, count, wrap, sat_flag};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL down_sat step=%0d got=%h exp=%h", i, got, e); end
    end
    en = 1'b0;
    exp_q.push_back({8'h00, 8'd0, 1'b0, 1'b1});
    step_cycle();
    got = {8'h00, count, wrap, sat_flag};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL sat_sticky got=%h exp=%h", got, e); end
    clr = 1'b1;
    exp_q.push_back({8'h00, 8'd0, 1'b0, 1'b0});
    step_cycle();
    got = {8'h00, count, wrap, sat_flag};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL clr_sat got=%h exp=%h", got, e); end
    clr = 1'b0; en = 1'b1;
  endtask

  task automatic test_load_clamp();
    logic [SB_W-1:0] got, e;
    sat_mode = 1'b0; up = 1'b1;
    for (int k = 0; k < 3; k++) begin
      load = 1'b1; load_val = 8'd200; limit = 8'd50;
      exp_q.push_back({8'h00, 8'd50, 1'b0, 1'b0});
      step_cycle();
      got = {8'h00, count, wrap, sat_flag};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL load_clamp got=%h exp=%h", got, e); end
      load = 1'b0; limit = 8'd20;
      up = (k != 1);
      sat_mode = (k == 2);
      case (k)
        0: exp_q.push_back({8'h00, 8'd0, 1'b1, 1'b0});
        1: exp_q.push_back({8'h00, 8'd20, 1'b0, 1'b0});
        default: exp_q.push_back({8'h00, 8'd20, 1'b0, 1'b1});
      endcase
      step_cycle();
      got = {8'h00, count, wrap, sat_flag};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL limit_shrink case=%0d got=%h exp=%h", k, got, e); end
    end
    clr = 1'b1; sat_mode = 1'b0; up = 1'b1;
    step_cycle();
    clr = 1'b0;
  endtask

  task automatic test_gating();
    logic [SB_W-1:0] got, e;
    limit = 8'd9; load = 1'b1; load_val = 8'd3;
    step_cycle();
    load = 1'b0; en = 1'b1; cin = 1'b0; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({8'h00, 8'd3, 1'b0, 1'b0});
      step_cycle();
      got = {8'h00, count, wrap, sat_flag};
      e = exp_q.pop_front();
      checks++;
      if (got !== e || cout !== 1'b0) begin
        errors++; $display("FAIL gate_cin got=%h cout=%b exp=%h cout=0", got, cout, e);
      end
    end
    cin = 1'b1;
  endtask

  task automatic test_limit_zero();
    logic [SB_W-1:0] got, e;
    clr = 1'b1;
    step_cycle();
    clr = 1'b0; limit = 8'd0; sat_mode = 1'b0; en = 1'b1; cin = 1'b1;
    for (int i = 0; i < 6; i++) begin
      up = (i < 3);
      sat_mode = (i >= 4);
      #1;
      checks++;
      if ({tc, cout} !== {1'b1, (i < 4)}) begin
        errors++; $display("FAIL lim0_tc_cout step=%0d got=%b%b exp=1%b", i, tc, cout, i < 4);
      end
      exp_q.push_back({8'h00, 8'd0, (i < 4), (i >= 4)});
      step_cycle();
      got = {8'h00, count, wrap, sat_flag};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL limit_zero step=%0d got=%h exp=%h", i, got, e); end
    end
    en = 1'b0; sat_mode = 1'b0;
  endtask

  task automatic test_cascade();
    logic [SB_W-1:0] got, e;
    c_clr = 1'b1;
    step_cycle();
    c_clr = 1'b0; c_en = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      exp_q.push_back({8'(k / 10), 8'(k % 10), 2'b00});
      step_cycle();
      got = {hi_count, lo_count, 2'b00};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL cascade step=%0d got=%h exp=%h", k, got, e); end
    end
    c_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; limit = 8'd9;
    en = 1'b0; cin = 1'b1; up = 1'b1; sat_mode = 1'b0;
    c_clr = 1'b0; c_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_load_clamp();
    test_gating();
    test_limit_zero();
    test_cascade();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drain got=%0d exp=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised, loadable up/down modulo counter: successor to the fixed-modulus up-counter.
- Adds the following features:
  - run-time modulus (`limit`);
  - direction control;
  - wrap or saturate mode;
  - synchronous clear and load;
  - cascade carry-in/carry-out;
  - registered wrap pulse and sticky saturation flag.
- Used for address/index sequencing and multi-digit counter chains in datapath controllers.

Parameters:
- WIDTH, 8, counter and limit width in bits (>=1).
- RESET_VAL, 0, value of `count` after `rst`.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous load of `load_val`.
- load_val  input  WIDTH  value to load.
- limit  input  WIDTH  maximum count value. The count range is 0..limit, i.e. modulus limit+1.
- en  input  1  count enable.
- cin  input  1  cascade carry-in. Tie to 1 when not cascaded.
- up  input  1  1 = count up, 0 = count down.
- sat_mode  input  1  1 = saturate at end of range, 0 = wrap.
- count  output  WIDTH  registered count value.
- tc  output  1  combinational terminal count: (up & count>=limit) | (!up & count==0).
- cout  output  1  combinational cascade carry-out = tc & en & cin & !sat_mode.
- wrap  output  1  registered one-cycle pulse, set in the cycle after a wrap occurred.
- sat_flag  output  1  registered sticky flag, set when a step is blocked by saturation.

Behaviour:
- Reset (async, rst=1):
  - count = RESET_VAL;
  - wrap = 0;
  - sat_flag = 0.
  - rst overrides everything, including mid-operation.
- Step condition: step = en & cin.
- Priority per rising clk edge: clr > load > step > hold.
- clr=1:
  - count <= 0;
  - wrap <= 0;
  - sat_flag <= 0.
  - Overrides load and step in the same cycle.
- load=1 (clr=0):
  - count <= min(load_val, limit);
  - wrap <= 0;
  - sat_flag unchanged.
- Step, up=1:
  - count < limit: count <= count+1.
  - count >= limit, sat_mode=0: count <= 0; wrap <= 1.
  - count >= limit, sat_mode=1: count holds at limit (or is forced to limit if count > limit); sat_flag <= 1.
- Step, up=0:
  - count > limit (limit lowered at run time): count <= limit; no wrap.
  - 0 < count <= limit: count <= count-1.
  - count == 0, sat_mode=0: count <= limit; wrap <= 1.
  - count == 0, sat_mode=1: count holds at 0; sat_flag <= 1.
- Any cycle without a wrap event: wrap <= 0. The pulse is exactly one cycle wide per wrap.
- No step (en=0 or cin=0): count holds; wrap <= 0.
- limit=0 edge case:
  - the count stays at 0;
  - in wrap mode every step asserts wrap;
  - in saturate mode every step sets sat_flag.
- Arithmetic: all compares are unsigned WIDTH-bit. The +1 and -1 never overflow because they are taken only inside the checked ranges.
- Direction or sat_mode changes take effect on the next edge. No internal state other than count, wrap and sat_flag.
- tc and cout are purely combinational from current inputs and count. No latency.
- Cascade:
  - Connect lower-stage cout to upper-stage cin.
  - Each stage shares en.
  - The upper stage steps in the same cycle the lower stage wraps.
- Latency: count updates one clock after the qualifying inputs; wrap is asserted together with the updated count.

Test Plan:
- Reset and clear: set RESET_VAL=5, WIDTH=8. Assert rst mid-count with count=9 -> count=5, wrap=0, sat_flag=0 asynchronously. Then clr=1 with load=1, en=1 -> count=0.
- Up-wrap: limit=9, up=1, sat_mode=0, en=cin=1, start at 0, run 12 clocks.
  - count sequence 0..9,0,1,2.
  - tc=1 and cout=1 only at count 9.
  - wrap=1 for exactly the one cycle where count shows 0 after 9.
- Down/saturate: limit=9, up=0, sat_mode=1, load_val=2.
  - Load, then step 4 times -> counts 1, 0, 0, 0.
  - sat_flag rises after the first blocked step and stays 1 until clr.
  - wrap is never asserted.
- Load clamp and limit shrink:
  - load_val=200 with limit=50 -> count=50.
  - Then set limit=20: up in wrap mode -> count=0 with wrap=1; down -> count=20 with wrap=0.
- Cascade of two stages, each limit=9, lower cout driving upper cin, 25 steps from 0 -> upper=2, lower=5. The upper stage increments exactly on lower 9->0 transitions.
- Gating: en=1, cin=0 for 3 cycles -> count holds, wrap=0. limit=0 in wrap mode -> count stays 0 and wrap=1 on every step.
